// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit. Takes the EX/MEM register contents, issues a
//   valid/ready request to data memory for doubleword loads and stores, waits
//   for the load response, stalls the upstream pipeline while an access is
//   outstanding and owns the MEM/WB register.
//
//   Misaligned doubleword accesses never reach memory. They retire as a
//   bubble and set the sticky MemErr flag. Accesses that stay in the wait
//   states for TIMEOUT cycles are handled the same way.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ALUResultM .. ExtImmM     M-stage fields from the EX/MEM register
//   dmem_req_valid/ready      request handshake (we/addr/wdata qualify it)
//   dmem_resp_valid/rdata     load response
//   StallM                    freeze IF..EX/MEM this cycle (combinational)
//   MemErr                    sticky misalign/timeout error, cleared by rst
//   *W                        MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ALUResultM,
    input  logic [63:0] WriteDataM,
    input  logic [63:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [63:0] ExtImmM,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_resp_valid,
    input  logic [63:0] dmem_rdata,
    output logic        StallM,
    output logic        MemErr,
    output logic [63:0] ALUResultW,
    output logic [63:0] ReadDataW,
    output logic [63:0] PCPlus4W,
    output logic [63:0] ExtImmW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACC  = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [TW-1:0]   tmo_r;
    logic [TW-1:0]   tmo_nx_s;
    logic            memop_s;
    logic            mis_s;
    logic            req_valid_s;
    logic            acc_s;
    logic            tmo_hit_s;
    logic            retire_s;
    logic            load_ret_s;
    logic            err_set_s;
    logic            stall_s;

    // Request handshake terms and the FSM next-state / retire decision.
    always_comb begin
        memop_s     = MemWriteM | (ResultSrcM == 2'b01);
        mis_s       = memop_s & (ALUResultM[2:0] != 3'b000);
        req_valid_s = !rst && !mis_s && memop_s &&
                      ((state_r == IDLE) || (state_r == WAIT_ACC));
        acc_s       = req_valid_s & dmem_req_ready;
        // Last permitted wait cycle: without completion the access aborts.
        tmo_hit_s   = (state_r != IDLE) && (tmo_r == TMO_LAST);

        state_nx_s  = state_r;
        retire_s    = 1'b0;
        load_ret_s  = 1'b0;
        err_set_s   = 1'b0;
        stall_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (!memop_s) begin
                    retire_s = 1'b1;
                end else if (mis_s) begin
                    err_set_s = 1'b1;
                end else if (acc_s && MemWriteM) begin
                    retire_s = 1'b1;
                end else if (acc_s) begin
                    state_nx_s = WAIT_RESP;
                    stall_s    = 1'b1;
                end else begin
                    state_nx_s = WAIT_ACC;
                    stall_s    = 1'b1;
                end
            end
            WAIT_ACC: begin
                if (acc_s && MemWriteM) begin
                    retire_s   = 1'b1;
                    state_nx_s = IDLE;
                end else if (tmo_hit_s) begin
                    // A load accepted on the last cycle still aborts: its
                    // response could only arrive after the budget expired.
                    err_set_s  = 1'b1;
                    state_nx_s = IDLE;
                end else if (acc_s) begin
                    state_nx_s = WAIT_RESP;
                    stall_s    = 1'b1;
                end else begin
                    stall_s    = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (dmem_resp_valid) begin
                    retire_s   = 1'b1;
                    load_ret_s = 1'b1;
                    state_nx_s = IDLE;
                end else if (tmo_hit_s) begin
                    err_set_s  = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    stall_s    = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        if (state_nx_s == IDLE) begin
            tmo_nx_s = {TW{1'b0}};
        end else if (state_r == IDLE) begin
            tmo_nx_s = {TW{1'b0}};
        end else begin
            tmo_nx_s = tmo_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign dmem_req_valid = req_valid_s;
    assign dmem_we        = MemWriteM;
    assign dmem_addr      = ALUResultM;
    assign dmem_wdata     = WriteDataM;
    assign StallM         = stall_s & !rst;

    // FSM state, timeout counter, sticky error and the MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tmo_r      <= {TW{1'b0}};
            MemErr     <= 1'b0;
            ALUResultW <= 64'd0;
            ReadDataW  <= 64'd0;
            PCPlus4W   <= 64'd0;
            ExtImmW    <= 64'd0;
            RdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            state_r <= state_nx_s;
            tmo_r   <= tmo_nx_s;
            if (err_set_s) begin
                MemErr <= 1'b1;
            end
            if (retire_s) begin
                ALUResultW <= ALUResultM;
                ReadDataW  <= load_ret_s ? dmem_rdata : 64'd0;
                PCPlus4W   <= PCPlus4M;
                ExtImmW    <= ExtImmM;
                RdW        <= RdM;
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
            end else begin
                // Stalled cycle, misalign or abort: send a bubble to WB.
                ALUResultW <= 64'd0;
                ReadDataW  <= 64'd0;
                PCPlus4W   <= 64'd0;
                ExtImmW    <= 64'd0;
                RdW        <= 5'd0;
                RegWriteW  <= 1'b0;
                ResultSrcW <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic [63:0] ALUResultM, WriteDataM, PCPlus4M, ExtImmM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_resp_valid;
    logic [63:0] dmem_rdata;
    logic        StallM, MemErr;
    logic [63:0] ALUResultW, ReadDataW, PCPlus4W, ExtImmW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    mem_stage_lsu #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ExtImmM(ExtImmM),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MemErr(MemErr),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ExtImmW(ExtImmW), .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and
    // sampled well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input logic rw, input logic mw,
                          input logic [1:0] rs);
        ALUResultM = addr; WriteDataM = wdata; RdM = rd;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        PCPlus4M = 64'h1004; ExtImmM = 64'h10;
        #1;
    endtask

    initial begin
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = 64'd0;
        rst = 1'b1;
        // Load presented during reset: no request, no stall.
        set_op(64'h200, 64'd0, 5'd7, 1'b1, 1'b0, 2'b01);
        chk("rst_stall", {63'd0, StallM}, 64'd0);
        chk("rst_reqv", {63'd0, dmem_req_valid}, 64'd0);
        tick(); tick();
        chk("rst_rdw", {59'd0, RdW}, 64'd0);
        chk("rst_aluw", ALUResultW, 64'd0);
        chk("rst_err", {63'd0, MemErr}, 64'd0);
        rst = 1'b0;

        // ALU op retires in one cycle.
        set_op(64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 2'b00);
        chk("alu_stall", {63'd0, StallM}, 64'd0);
        chk("alu_reqv", {63'd0, dmem_req_valid}, 64'd0);
        tick();
        chk("alu_rdw", {59'd0, RdW}, 64'd5);
        chk("alu_aluw", ALUResultW, 64'h1234);
        chk("alu_rwW", {63'd0, RegWriteW}, 64'd1);
        chk("alu_pc4w", PCPlus4W, 64'h1004);

        // Store accepted immediately.
        dmem_req_ready = 1'b1;
        set_op(64'h100, 64'hAA, 5'd0, 1'b0, 1'b1, 2'b00);
        chk("st_reqv", {63'd0, dmem_req_valid}, 64'd1);
        chk("st_we", {63'd0, dmem_we}, 64'd1);
        chk("st_addr", dmem_addr, 64'h100);
        chk("st_wdata", dmem_wdata, 64'hAA);
        chk("st_stall", {63'd0, StallM}, 64'd0);
        tick();
        chk("st_rwW", {63'd0, RegWriteW}, 64'd0);
        chk("st_aluw", ALUResultW, 64'h100);
        dmem_req_ready = 1'b0;

        // Load: ready low 2 cycles, response 3 cycles after acceptance.
        set_op(64'h200, 64'd0, 5'd7, 1'b1, 1'b0, 2'b01);
        chk("ld_c0_stall", {63'd0, StallM}, 64'd1);
        chk("ld_c0_reqv", {63'd0, dmem_req_valid}, 64'd1);
        chk("ld_c0_we", {63'd0, dmem_we}, 64'd0);
        tick();
        chk("ld_c1_bubble", {63'd0, RegWriteW}, 64'd0);
        chk("ld_c1_stall", {63'd0, StallM}, 64'd1);
        chk("ld_c1_reqv", {63'd0, dmem_req_valid}, 64'd1);
        tick();
        dmem_req_ready = 1'b1; #1;
        chk("ld_c2_stall", {63'd0, StallM}, 64'd1);
        chk("ld_c2_reqv", {63'd0, dmem_req_valid}, 64'd1);
        tick();
        dmem_req_ready = 1'b0; #1;
        chk("ld_c3_reqv", {63'd0, dmem_req_valid}, 64'd0);
        chk("ld_c3_stall", {63'd0, StallM}, 64'd1);
        tick();
        chk("ld_c4_stall", {63'd0, StallM}, 64'd1);
        chk("ld_c4_bubble", {63'd0, RegWriteW}, 64'd0);
        tick();
        dmem_resp_valid = 1'b1; dmem_rdata = 64'hDEAD; #1;
        chk("ld_c5_stall", {63'd0, StallM}, 64'd0);
        tick();
        dmem_resp_valid = 1'b0;
        chk("ld_rdataW", ReadDataW, 64'hDEAD);
        chk("ld_rsW", {62'd0, ResultSrcW}, 64'd1);
        chk("ld_rdW", {59'd0, RdW}, 64'd7);
        chk("ld_rwW", {63'd0, RegWriteW}, 64'd1);
        chk("ld_aluW", ALUResultW, 64'h200);

        // Stray response in IDLE is ignored by a plain ALU op.
        dmem_resp_valid = 1'b1; dmem_rdata = 64'hBEEF;
        set_op(64'h77, 64'd0, 5'd3, 1'b1, 1'b0, 2'b00);
        chk("stray_stall", {63'd0, StallM}, 64'd0);
        tick();
        dmem_resp_valid = 1'b0;
        chk("stray_rdataW", ReadDataW, 64'd0);

        // Misaligned load.
        dmem_req_ready = 1'b1;
        set_op(64'h204, 64'd0, 5'd9, 1'b1, 1'b0, 2'b01);
        chk("mis_reqv", {63'd0, dmem_req_valid}, 64'd0);
        chk("mis_stall", {63'd0, StallM}, 64'd0);
        chk("mis_err_pre", {63'd0, MemErr}, 64'd0);
        tick();
        chk("mis_rwW", {63'd0, RegWriteW}, 64'd0);
        chk("mis_rdW", {59'd0, RdW}, 64'd0);
        chk("mis_err", {63'd0, MemErr}, 64'd1);
        set_op(64'h8, 64'd0, 5'd1, 1'b1, 1'b0, 2'b00);
        tick();
        chk("mis_err_sticky", {63'd0, MemErr}, 64'd1);
        chk("after_mis_rdW", {59'd0, RdW}, 64'd1);

        // Reset clears the sticky error.
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("err_cleared", {63'd0, MemErr}, 64'd0);

        // Timeout: load accepted, never answered.
        set_op(64'h300, 64'd0, 5'd4, 1'b1, 1'b0, 2'b01);
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            if (!StallM) break;
            stalls++;
            chk("tmo_bubble", {63'd0, RegWriteW}, 64'd0);
            tick();
        end
        chk("tmo_stall_cycles", 64'(stalls), 64'd8);
        tick();
        chk("tmo_rwW", {63'd0, RegWriteW}, 64'd0);
        chk("tmo_err", {63'd0, MemErr}, 64'd1);
        // Back in IDLE: a store is accepted and retires without stalling.
        set_op(64'h308, 64'h55, 5'd0, 1'b0, 1'b1, 2'b00);
        chk("tmo_idle_stall", {63'd0, StallM}, 64'd0);
        chk("tmo_idle_reqv", {63'd0, dmem_req_valid}, 64'd1);
        tick();

        // Reset while waiting for a response; late response ignored.
        rst = 1'b1; tick(); rst = 1'b0;
        set_op(64'h400, 64'd0, 5'd6, 1'b1, 1'b0, 2'b01);
        chk("rr_stall", {63'd0, StallM}, 64'd1);
        tick();
        chk("rr_in_resp_reqv", {63'd0, dmem_req_valid}, 64'd0);
        rst = 1'b1; #1;
        chk("rr_stall_rst", {63'd0, StallM}, 64'd0);
        tick();
        rst = 1'b0;
        dmem_req_ready = 1'b0;
        set_op(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b00);
        dmem_resp_valid = 1'b1; dmem_rdata = 64'h5555; #1;
        chk("rr_rdataW0", ReadDataW, 64'd0);
        chk("rr_stall_after", {63'd0, StallM}, 64'd0);
        chk("rr_reqv_after", {63'd0, dmem_req_valid}, 64'd0);
        tick();
        dmem_resp_valid = 1'b0;
        chk("rr_late_rdataW", ReadDataW, 64'd0);
        chk("rr_late_rwW", {63'd0, RegWriteW}, 64'd0);
        chk("rr_err", {63'd0, MemErr}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
